// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and default 640x480@60 constants.
// Used by the horizontal and vertical timing stages.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    FRONT_PORCH  = 2'd0,
    SYNC_PULSE   = 2'd1,
    BACK_PORCH   = 2'd2,
    ACTIVE_VIDEO = 2'd3
  } vga_state_e;

  localparam int H_FRONT_PORCH = 16;
  localparam int H_SYNC_PULSE  = 96;
  localparam int H_BACK_PORCH  = 48;
  localparam int H_ACTIVE      = 640;

  localparam int V_FRONT_PORCH = 10;
  localparam int V_SYNC_PULSE  = 2;
  localparam int V_BACK_PORCH  = 33;
  localparam int V_ACTIVE      = 480;

endpackage

// File: rtl/vertical_state_machine_if.sv
// Vertical timing bus: end-of-line pulse in, vertical qualifiers out.
// master = upstream/consumer side, slave = vertical_state_machine.
interface vertical_state_machine_if #(
  parameter int COUNT_WIDTH = 10
);

  logic                   line_increment_i;
  logic                   vertical_active_video_o;
  logic                   sync_pulse_o;
  logic [COUNT_WIDTH-1:0] row_o;
  logic                   frame_done_o;

  modport master (
    output line_increment_i,
    input  vertical_active_video_o,
    input  sync_pulse_o,
    input  row_o,
    input  frame_done_o
  );

  modport slave (
    input  line_increment_i,
    output vertical_active_video_o,
    output sync_pulse_o,
    output row_o,
    output frame_done_o
  );

endinterface

// File: rtl/vertical_state_machine.sv
// Vertical timing stage: counts lines, sequences porch/sync/active.
// Ports: clk_i, rst_ni, bus (line_increment_i in; video/vsync/row/frame_done out).
import vga_timing_pkg::*;

module vertical_state_machine #(
  parameter int FRONT_PORCH_LINES = V_FRONT_PORCH,
  parameter int SYNC_PULSE_LINES  = V_SYNC_PULSE,
  parameter int BACK_PORCH_LINES  = V_BACK_PORCH,
  parameter int ACTIVE_LINES      = V_ACTIVE,
  parameter int COUNT_WIDTH       = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  vertical_state_machine_if.slave  bus
);

  localparam logic [COUNT_WIDTH-1:0] FP_LAST =
    COUNT_WIDTH'(FRONT_PORCH_LINES - 1);
  localparam logic [COUNT_WIDTH-1:0] SP_LAST =
    COUNT_WIDTH'(SYNC_PULSE_LINES - 1);
  localparam logic [COUNT_WIDTH-1:0] BP_LAST =
    COUNT_WIDTH'(BACK_PORCH_LINES - 1);
  localparam logic [COUNT_WIDTH-1:0] AV_LAST =
    COUNT_WIDTH'(ACTIVE_LINES - 1);

  vga_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   frame_done_q, frame_done_d;

  logic [COUNT_WIDTH-1:0] last_line;
  vga_state_e             next_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= FRONT_PORCH;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    last_line    = FP_LAST;
    next_state   = SYNC_PULSE;
    state_d      = state_q;
    count_d      = count_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      FRONT_PORCH: begin
        last_line  = FP_LAST;
        next_state = SYNC_PULSE;
      end
      SYNC_PULSE: begin
        last_line  = SP_LAST;
        next_state = BACK_PORCH;
      end
      BACK_PORCH: begin
        last_line  = BP_LAST;
        next_state = ACTIVE_VIDEO;
      end
      ACTIVE_VIDEO: begin
        last_line  = AV_LAST;
        next_state = FRONT_PORCH;
      end
      default: ;
    endcase

    if (bus.line_increment_i) begin
      if (count_q == last_line) begin
        count_d      = '0;
        state_d      = next_state;
        // Leaving the last visible line closes the frame.
        frame_done_d = (state_q == ACTIVE_VIDEO);
      end else begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    bus.vertical_active_video_o = 1'b0;
    bus.sync_pulse_o            = 1'b1;
    bus.row_o                   = '0;
    unique case (1'b1)
      (state_q == SYNC_PULSE): bus.sync_pulse_o = 1'b0;
      (state_q == ACTIVE_VIDEO): begin
        bus.vertical_active_video_o = 1'b1;
        bus.row_o                   = count_q;
      end
      default: ;
    endcase
    bus.frame_done_o = frame_done_q;
  end

endmodule

// File: tb/tb_vertical_state_machine.sv
// Self-checking bench for vertical_state_machine.
// Reference model tracks total lines since reset modulo the frame.
module tb_vertical_state_machine;

  localparam int FP  = 10;
  localparam int SP  = 2;
  localparam int BP  = 33;
  localparam int AV  = 480;
  localparam int TOT = FP + SP + BP + AV;

  logic clk_i;
  logic rst_ni;

  vertical_state_machine_if #(.COUNT_WIDTH(10)) vif ();

  vertical_state_machine #(
    .FRONT_PORCH_LINES(FP),
    .SYNC_PULSE_LINES (SP),
    .BACK_PORCH_LINES (BP),
    .ACTIVE_LINES     (AV),
    .COUNT_WIDTH      (10)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (vif.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int lines  = 0;
  bit exp_fd = 1'b0;
  int fd_seen = 0;

  function automatic int pos();
    return lines % TOT;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d (line %0d)",
             tag, obs, exp, lines);
    end
  endtask

  task automatic chk_all(input string tag);
    int p;
    int e_act;
    int e_sync;
    int e_row;
    p      = pos();
    e_act  = (p >= FP + SP + BP) ? 1 : 0;
    e_sync = (p >= FP && p < FP + SP) ? 0 : 1;
    e_row  = e_act ? p - (FP + SP + BP) : 0;
    chk({tag, ".active"}, int'(vif.vertical_active_video_o), e_act);
    chk({tag, ".vsync"}, int'(vif.sync_pulse_o), e_sync);
    chk({tag, ".row"}, int'(vif.row_o), e_row);
    chk({tag, ".fdone"}, int'(vif.frame_done_o), int'(exp_fd));
  endtask

  task automatic cyc(input bit inc, input string tag);
    vif.line_increment_i = inc;
    @(posedge clk_i);
    #1;
    exp_fd = inc && (pos() == TOT - 1);
    if (inc) lines++;
    if (vif.frame_done_o === 1'b1) fd_seen++;
    chk_all(tag);
  endtask

  task automatic rst_cyc(input bit inc);
    vif.line_increment_i = inc;
    @(posedge clk_i);
    #1;
    chk_all("rst");
  endtask

  task automatic async_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    lines  = 0;
    exp_fd = 1'b0;
    chk_all("async_rst");
    for (int i = 0; i < 3; i++) rst_cyc(1'b1);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    vif.line_increment_i = 1'b0;
    for (int i = 0; i < 4; i++) rst_cyc(i[0]);
    rst_ni = 1'b1;

    fd_seen = 0;
    for (int i = 0; i < 2 * TOT; i++) cyc(1'b1, "b2b");
    chk("b2b.fd_count", fd_seen, 2);
    cyc(1'b0, "b2b_idle");

    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, "gap");
      for (int j = 0; j < 799; j++) cyc(1'b0, "gap_idle");
    end

    fd_seen = 0;
    for (int i = 0; i < 2600; i++)
      cyc(1'($urandom_range(0, 1)), "rand");

    for (int i = 0; i < TOT && pos() != FP + SP + BP + 200; i++)
      cyc(1'b1, "to_row200");
    chk("row200", int'(vif.row_o), 200);
    async_reset();
    for (int i = 0; i < FP - 1; i++) cyc(1'b1, "post_rst");
    chk("pre_sync", int'(vif.sync_pulse_o), 1);
    cyc(1'b1, "post_rst");
    chk("sync_low", int'(vif.sync_pulse_o), 0);

    for (int i = 0; i < TOT && pos() != TOT - 1; i++)
      cyc(1'b1, "to_end");
    cyc(1'b1, "frame_end");
    chk("fd_pending", int'(vif.frame_done_o), 1);
    async_reset();
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom_range(0, 1)), "tail");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vertical_state_machine.md
Name: vertical_state_machine

Overview:
- Vertical timing stage. Sits directly downstream of the horizontal state machine and consumes its one-cycle end-of-line pulse (vertical_counter_increment).
- Keeps an internal line counter and sequences front porch, sync pulse, back porch and active video in units of lines.
- Produces the vertical active-video qualifier, active-low vsync, the active row index and an end-of-frame pulse for the pixel/framebuffer logic.

Parameters:
- FRONT_PORCH_LINES, 10, lines in the vertical front porch (>=1)
- SYNC_PULSE_LINES, 2, lines with vsync asserted low (>=1)
- BACK_PORCH_LINES, 33, lines in the vertical back porch (>=1)
- ACTIVE_LINES, 480, visible lines (>=1)
- COUNT_WIDTH, 10, line counter and row width; must hold max(parameter)-1

Ports:
- clk_i  input  1  pixel clock, same clock as the horizontal state machine
- rst_ni  input  1  asynchronous active-low reset
- line_increment_i  input  1  end-of-line pulse from the horizontal stage; one line per high cycle
- vertical_active_video_o  output  1  high while in ACTIVE_VIDEO (Moore)
- sync_pulse_o  output  1  vsync, low only in SYNC_PULSE (Moore)
- row_o  output  COUNT_WIDTH  current visible row 0..ACTIVE_LINES-1 in ACTIVE_VIDEO, 0 otherwise
- frame_done_o  output  1  registered one-cycle pulse at end of frame

Behaviour:
- Reset (rst_ni low, asynchronous assert, synchronous-to-clk deassert use): state=FRONT_PORCH, line count=0, frame_done_o=0. Outputs at reset: vertical_active_video_o=0, sync_pulse_o=1, row_o=0.
- States: FRONT_PORCH -> SYNC_PULSE -> BACK_PORCH -> ACTIVE_VIDEO -> FRONT_PORCH. 2-bit encoding 0..3 in that order.
- Each state lasts exactly N lines, where N is its parameter. In each state the line count advances only on a clk_i edge with line_increment_i=1.
- If line_increment_i=1 and count==N-1: count clears to 0 and the state advances on the same edge. Otherwise, with line_increment_i=1, count increments.
- With line_increment_i=0, state and count hold indefinitely. No timeout.
- line_increment_i held high for k consecutive cycles counts k lines. No edge detection.
- Moore outputs depend on state only: vertical_active_video_o=1 only in ACTIVE_VIDEO; sync_pulse_o=0 only in SYNC_PULSE.
- row_o equals the line count in ACTIVE_VIDEO and is forced to 0 elsewhere. It never exceeds ACTIVE_LINES-1.
- frame_done_o is a flop. It is set for exactly one cycle following the edge on which ACTIVE_VIDEO transitions to FRONT_PORCH, and is 0 otherwise.
- Frame period is FRONT+SYNC+BACK+ACTIVE increments; 525 at defaults.
- The first increment after reset counts as front-porch line 0.
- Reset mid-operation, in any state: immediate return to FRONT_PORCH with count=0. A pending frame_done_o is cleared.
- Count comparison is unsigned at COUNT_WIDTH. Any count wrap is unreachable by construction.
- Latency: outputs reflect a transition in the cycle after the incrementing edge. There is no combinational path from line_increment_i to any output.

Decomposition:
- Shared package vga_timing_pkg:
  - state localparams (FRONT_PORCH=0, SYNC_PULSE=1, BACK_PORCH=2, ACTIVE_VIDEO=3), shared with the horizontal stage
  - default 640x480@60 horizontal and vertical timing constants
- No sub-module. The line counter and FSM are small enough to live in one module: one state/count register block, one next-state block and one Moore output block.

Test Plan:
- Reset: hold rst_ni=0, toggle increments -> state FRONT_PORCH, sync_pulse_o=1, vertical_active_video_o=0, row_o=0, frame_done_o=0.
- Porch/sync timing: apply increments 1..10 -> sync_pulse_o falls after the 10th. Increment 12 -> sync_pulse_o rises. Increment 45 -> vertical_active_video_o=1, row_o=0.
- Row tracking: in ACTIVE_VIDEO, each increment -> row_o steps 0..479. Increment 525 -> active drops, row_o=0, frame_done_o=1 for exactly one cycle. The next frame repeats identically.
- Gaps: increments spaced 800 cycles apart with idle cycles between -> state and count unchanged during idle. Results match the back-to-back case.
- Back-to-back: line_increment_i held high 525 cycles -> full frame in 525 cycles, frame_done_o pulses once.
- Mid-frame reset: assert rst_ni low at row 200 for 3 cycles, asynchronously off a clock edge -> outputs go to reset values immediately. After release, 10 more increments are needed before sync_pulse_o goes low.
